// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: FSM states, fault cause codes and
// instruction-word constants.
package cpu_pkg;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        HALT  = 3'd3,
        FAULT = 3'd4
    } fetch_state_e;

    localparam logic [1:0]  FAULT_NONE        = 2'b00;
    localparam logic [1:0]  FAULT_MISALIGN    = 2'b01;
    localparam logic [1:0]  FAULT_TIMEOUT     = 2'b10;

    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] WORD_BYTES        = 32'd4;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Loadable 8-bit up-counter measuring how long a fetch has waited for memory;
// term_o flags the last permitted wait cycle.
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       inc_i,
    output logic       term_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch for the single-cycle core: fetches
// over a req/ready handshake, issues to decode, and stops on halt or fault.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD,
    parameter int          TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcInstruction,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [1:0]   cause_q, cause_d;
    logic         ctr_clr, ctr_inc, ctr_term;

    fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk_i      (clk),
        .rst_i      (reset),
        .clr_i      (ctr_clr),
        .load_i     (1'b0),
        .load_val_i (8'd0),
        .inc_i      (ctr_inc),
        .term_o     (ctr_term)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cause_d = cause_q;
        ctr_clr = 1'b1;
        ctr_inc = 1'b0;
        unique case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = ISSUE;
                end else if (ctr_term) begin
                    cause_d = FAULT_TIMEOUT;
                    state_d = FAULT;
                end else begin
                    ctr_clr = 1'b0;
                    ctr_inc = 1'b1;
                end
            end
            ISSUE: begin
                // Stall outranks halt and fault so decode sees a stable word.
                if (stall) begin
                    state_d = ISSUE;
                end else if (instr_q == HALT_WORD) begin
                    state_d = HALT;
                end else if (pcInstruction[1:0] != 2'b00) begin
                    cause_d = FAULT_MISALIGN;
                    state_d = FAULT;
                end else begin
                    pc_d    = pcInstruction;
                    state_d = FETCH;
                end
            end
            HALT:    state_d = HALT;
            FAULT:   state_d = FAULT;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            cause_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cause_q <= cause_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc4         = pc_q + WORD_BYTES;
    assign instr       = instr_q;
    assign instr_valid = (state_q == ISSUE);
    assign halted      = (state_q == HALT);
    assign fault       = (state_q == FAULT);
    assign fault_cause = cause_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized
// instruction streams checked against a per-instruction transaction model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] HALTW  = 32'hFFFF_FFFF;
    localparam int          TMO    = 16;

    logic        clk;
    logic        reset;
    logic [31:0] pcInstruction;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        instr_valid;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_cause;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] cur_pc;

    pc_fetch_unit #(.RESET_PC(RST_PC), .HALT_WORD(HALTW), .TIMEOUT(TMO)) dut (
        .clk           (clk),
        .reset         (reset),
        .pcInstruction (pcInstruction),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .pc4           (pc4),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .halted        (halted),
        .fault         (fault),
        .fault_cause   (fault_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"},    pc, RST_PC);
        chk({tag, "_pc4"},   pc4, RST_PC + 32'd4);
        chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_halt"},  {31'd0, halted}, 32'd0);
        chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
        chk({tag, "_cause"}, {30'd0, fault_cause}, 32'd0);
    endtask

    // Asserts reset at the current time, checks it takes effect at once,
    // then releases it on the following falling edge.
    task automatic do_reset();
        reset         = 1'b1;
        stall         = 1'b0;
        imem_ready    = 1'b1;
        imem_rdata    = $urandom();
        pcInstruction = $urandom();
        #1;
        chk_reset_state("rst_async");
        @(negedge clk);
        chk_reset_state("rst_hold");
        reset      = 1'b0;
        imem_ready = 1'b0;
        cur_pc     = RST_PC;
    endtask

    // One instruction: lat wait cycles before ready (>= TMO means never ready),
    // nstall stalled ISSUE cycles, then nxt offered as the next PC.
    // outcome: 0 continue, 1 halted, 2 faulted.
    task automatic fetch_one(input logic [31:0] data, input int lat, input int nstall,
                             input logic [31:0] nxt, output int outcome);
        int          ncyc;
        logic [1:0]  cause;
        ncyc    = (lat >= TMO) ? TMO : lat + 1;
        outcome = 0;
        cause   = 2'b00;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            chk("f_req",   {31'd0, imem_req}, 32'd1);
            chk("f_addr",  imem_addr, cur_pc);
            chk("f_pc4",   pc4, cur_pc + 32'd4);
            chk("f_valid", {31'd0, instr_valid}, 32'd0);
            chk("f_fault", {31'd0, fault}, 32'd0);
            stall         = 1'b0;
            pcInstruction = $urandom();
            imem_ready    = (lat < TMO) && (i == lat);
            imem_rdata    = imem_ready ? data : $urandom();
        end
        if (lat >= TMO) begin
            outcome = 2;
            cause   = 2'b10;
        end else begin
            for (int s = 0; s <= nstall; s++) begin
                @(negedge clk);
                chk("i_valid", {31'd0, instr_valid}, 32'd1);
                chk("i_instr", instr, data);
                chk("i_pc",    pc, cur_pc);
                chk("i_req",   {31'd0, imem_req}, 32'd0);
                stall         = (s < nstall);
                pcInstruction = (s < nstall) ? $urandom() : nxt;
                imem_ready    = 1'($urandom_range(0, 1));
                imem_rdata    = $urandom();
            end
            if (data == HALTW) begin
                outcome = 1;
            end else if (nxt[1:0] != 2'b00) begin
                outcome = 2;
                cause   = 2'b01;
            end else begin
                cur_pc = nxt;
            end
        end
        stall = 1'b0;
        if (outcome != 0) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("t_halt",  {31'd0, halted}, {31'd0, outcome == 1});
                chk("t_fault", {31'd0, fault}, {31'd0, outcome == 2});
                chk("t_cause", {30'd0, fault_cause}, {30'd0, cause});
                chk("t_req",   {31'd0, imem_req}, 32'd0);
                chk("t_valid", {31'd0, instr_valid}, 32'd0);
                chk("t_pc",    pc, cur_pc);
                imem_ready    = 1'($urandom_range(0, 1));
                pcInstruction = $urandom();
            end
        end
    endtask

    initial begin
        int          o;
        logic [31:0] d;
        logic [31:0] nxt;
        logic [31:0] tmp;
        int          lat;

        reset         = 1'b1;
        stall         = 1'b0;
        imem_ready    = 1'b0;
        imem_rdata    = 32'd0;
        pcInstruction = 32'd0;
        cur_pc        = RST_PC;
        @(negedge clk);
        do_reset();

        fetch_one(32'h1234_5678, 0, 0, 32'h0000_0004, o);
        fetch_one($urandom(), 5, 0, 32'h0000_0008, o);
        fetch_one($urandom(), 0, 3, 32'h0000_0040, o);
        @(negedge clk);
        chk("mid_fetch_addr", imem_addr, 32'h0000_0040);
        chk("mid_fetch_req", {31'd0, imem_req}, 32'd1);
        do_reset();

        fetch_one($urandom() & 32'h7FFF_FFFF, 0, 0, 32'h0000_0102, o);
        do_reset();
        fetch_one(HALTW, 1, 0, 32'h0000_0008, o);
        do_reset();
        fetch_one($urandom(), 20, 0, 32'h0, o);
        do_reset();
        fetch_one($urandom() & 32'h7FFF_FFFF, TMO - 1, 0, 32'hFFFF_FFFC, o);
        fetch_one($urandom() & 32'h7FFF_FFFF, 2, 1, 32'h0000_0000, o);
        fetch_one($urandom() & 32'h7FFF_FFFF, 0, 0, 32'h0000_0010, o);

        for (int it = 0; it < 150; it++) begin
            d   = ($urandom_range(0, 19) == 0) ? HALTW : $urandom();
            lat = ($urandom_range(0, 9) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 3);
            tmp = $urandom();
            nxt = {tmp[31:2], 2'b00};
            if ($urandom_range(0, 9) == 0) nxt[1:0] = 2'($urandom_range(1, 3));
            fetch_one(d, lat, $urandom_range(0, 2), nxt, o);
            if (o != 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
